// File: rtl/muldiv_pkg.sv
// Shared types, constants and arithmetic helpers for the HI/LO multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StMul,
      StDiv,
      StFix,
      StDone
   } state_e;

   localparam int unsigned DIV_ITER    = 32;
   localparam logic [31:0] DZ_QUOTIENT = 32'hFFFF_FFFF;

   // Two's-complement negate.
   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   // Magnitude; 32'h8000_0000 maps to itself and is read as unsigned 2^31.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? neg32(v) : v;
   endfunction

   // Full 64-bit product, signed or unsigned.
   function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                         input logic is_unsigned);
      logic [63:0] ea;
      logic [63:0] eb;
      ea = is_unsigned ? {32'd0, a} : {{32{a[31]}}, a};
      eb = is_unsigned ? {32'd0, b} : {{32{b[31]}}, b};
      return ea * eb;
   endfunction

endpackage

// File: rtl/ex_muldiv_hilo_if.sv
// EX-stage request / HI-LO read bundle between the pipeline and the mul/div unit.
interface ex_muldiv_hilo_if;

   logic        start_mul;
   logic        start_div;
   logic        is_unsigned;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        mthi;
   logic        mtlo;
   logic [31:0] mt_data;
   logic        flush;
   logic        stall;
   logic [31:0] hi_rdata;
   logic [31:0] lo_rdata;

   // Pipeline side.
   modport master (
      output start_mul, start_div, is_unsigned, src1, src2, mthi, mtlo, mt_data, flush,
      input  stall, hi_rdata, lo_rdata
   );

   // Mul/div unit side.
   modport slave (
      input  start_mul, start_div, is_unsigned, src1, src2, mthi, mtlo, mt_data, flush,
      output stall, hi_rdata, lo_rdata
   );

endinterface

// File: rtl/ex_muldiv_hilo_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
module ex_muldiv_hilo_div_step (
   input  logic [32:0] rem_i,
   input  logic [31:0] dvd_i,
   input  logic [31:0] dvs_i,
   output logic [32:0] rem_o,
   output logic [31:0] dvd_o,
   output logic        qbit_o
);

   logic [33:0] shifted;
   logic [33:0] diff;

   // Borrow out of the 34-bit subtract means the divisor did not fit.
   always_comb begin
      shifted = {rem_i, dvd_i[31]};
      diff    = shifted - {2'b00, dvs_i};
      qbit_o  = ~diff[33];
      rem_o   = qbit_o ? diff[32:0] : shifted[32:0];
      dvd_o   = {dvd_i[30:0], 1'b0};
   end

endmodule

// File: rtl/ex_muldiv_hilo.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
module ex_muldiv_hilo
   import muldiv_pkg::*;
#(
   parameter int unsigned MUL_LAT = 2
) (
   input logic               clk,
   input logic               resetn,
   ex_muldiv_hilo_if.slave   bus
);

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] prod_q, prod_d;
   logic [32:0] rem_q, rem_d;
   logic [31:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] src1_q, src1_d; // original dividend, returned as HI on divide-by-zero
   logic        sign_q_q, sign_q_d;
   logic        sign_r_q, sign_r_d;
   logic        dz_q, dz_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [32:0] step_rem;
   logic [31:0] step_dvd;
   logic        step_qbit;

   ex_muldiv_hilo_div_step u_div_step (
      .rem_i  (rem_q),
      .dvd_i  (dvd_q),
      .dvs_i  (dvs_q),
      .rem_o  (step_rem),
      .dvd_o  (step_dvd),
      .qbit_o (step_qbit)
   );

   // Stall is held low during reset regardless of what the pipeline presents.
   assign bus.stall = resetn & (((state_q == StIdle) & (bus.start_mul | bus.start_div)) |
                                (state_q == StMul) | (state_q == StDiv) | (state_q == StFix));
   assign bus.hi_rdata = hi_q;
   assign bus.lo_rdata = lo_q;

   // Next-state and datapath: accept, iterate, commit, plus MT writes and flush override.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      src1_d   = src1_q;
      sign_q_d = sign_q_q;
      sign_r_d = sign_r_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      unique case (state_q)
         StIdle: begin
            // MT in the same cycle as a start suppresses the start.
            if (!(bus.mthi || bus.mtlo)) begin
               if (bus.start_div) begin
                  state_d  = StDiv;
                  dvd_d    = bus.is_unsigned ? bus.src1 : abs32(bus.src1);
                  dvs_d    = bus.is_unsigned ? bus.src2 : abs32(bus.src2);
                  sign_q_d = ~bus.is_unsigned & (bus.src1[31] ^ bus.src2[31]);
                  sign_r_d = ~bus.is_unsigned & bus.src1[31];
                  dz_d     = (bus.src2 == 32'd0);
                  src1_d   = bus.src1;
                  rem_d    = 33'd0;
                  cnt_d    = 5'(DIV_ITER - 1);
               end else if (bus.start_mul) begin
                  state_d = StMul;
                  prod_d  = mul64(bus.src1, bus.src2, bus.is_unsigned);
                  cnt_d   = 5'(MUL_LAT - 1);
               end
            end
         end
         StMul: begin
            if (cnt_q == 5'd0) begin
               hi_d    = prod_q[63:32];
               lo_d    = prod_q[31:0];
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         StDiv: begin
            rem_d = step_rem;
            dvd_d = step_dvd | {31'd0, step_qbit};
            if (cnt_q == 5'd0) begin
               state_d = StFix;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         StFix: begin
            if (dz_q) begin
               lo_d = DZ_QUOTIENT;
               hi_d = src1_q;
            end else begin
               lo_d = sign_q_q ? neg32(dvd_q) : dvd_q;
               hi_d = sign_r_q ? neg32(rem_q[31:0]) : rem_q[31:0];
            end
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if ((state_q == StIdle) || (state_q == StDone)) begin
         if (bus.mthi) hi_d = bus.mt_data;
         if (bus.mtlo) lo_d = bus.mt_data;
      end

      // Flush aborts everything and leaves HI/LO untouched.
      if (bus.flush) begin
         state_d = StIdle;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StIdle;
         cnt_q    <= 5'd0;
         prod_q   <= 64'd0;
         rem_q    <= 33'd0;
         dvd_q    <= 32'd0;
         dvs_q    <= 32'd0;
         src1_q   <= 32'd0;
         sign_q_q <= 1'b0;
         sign_r_q <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         src1_q   <= src1_d;
         sign_q_q <= sign_q_d;
         sign_r_q <= sign_r_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

endmodule
